fp_cvt_sched: RTL and testbench

- Shares one fp_cvt conversion datapath, and its downstream rounding stage, between two requesters: port 0 is the integer pipeline and port 1 is the FPU issue queue.
- Round-robin arbitration with valid/ready handshakes on both request ports.
- Issues at most one op per cycle into a fixed-latency pipe and tracks every in-flight op's owner in a shift register.
- Returns results through a credit-protected response FIFO that cannot overflow, and accumulates sticky fflags.

---
 rtl/fp_cvt_sched.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_fp_cvt_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cvt_sched.sv
// fp_cvt_sched: shares one fixed-latency fp_cvt datapath between the integer
// pipeline (port 0) and the FPU issue queue (port 1). Round-robin arbitration,
// one registered issue per cycle, owner tracking through a LAT-deep shift
// register, and a credit-protected response FIFO with sticky fflags.
module fp_cvt_sched #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op,
    input  logic [65:0] req_data,
    input  logic [19:0] req_class,
    input  logic [5:0]  req_rm,
    output logic        cvt_valid,
    output logic [1:0]  cvt_op,
    output logic [32:0] cvt_data,
    output logic [9:0]  cvt_class,
    output logic [2:0]  cvt_rm,
    input  logic        res_valid,
    input  logic [31:0] res_result,
    input  logic [4:0]  res_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    input  logic        flush,
    output logic [4:0]  fflags,
    input  logic        fflags_clr,
    output logic        err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = 1 + 32 + 5;

    // ------------------------------------------------------------------
    // Per-port field split
    // ------------------------------------------------------------------
    logic [1:0]  port_op    [2];
    logic [32:0] port_data  [2];
    logic [9:0]  port_class [2];
    logic [2:0]  port_rm    [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign port_op[gi]    = req_op[gi*2 +: 2];
        assign port_data[gi]  = req_data[gi*33 +: 33];
        assign port_class[gi] = req_class[gi*10 +: 10];
        assign port_rm[gi]    = req_rm[gi*3 +: 3];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic             rr_ptr_reg;
    logic [CNT_W-1:0] credits_reg;

    logic             cvt_valid_reg;
    logic             cvt_id_reg;
    logic [1:0]       cvt_op_reg;
    logic [32:0]      cvt_data_reg;
    logic [9:0]       cvt_class_reg;
    logic [2:0]       cvt_rm_reg;

    logic [LAT-1:0]   stage_valid_reg;
    logic [LAT-1:0]   stage_ghost_reg;
    logic [LAT-1:0]   stage_id_reg;
    logic [LAT-1:0]   stage_in_valid;
    logic [LAT-1:0]   stage_in_ghost;
    logic [LAT-1:0]   stage_in_id;

    logic [ENT_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic [4:0]       fflags_reg;
    logic             err_reg;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic             issue_ok;
    logic             gnt_any;
    logic             gnt_id;
    logic             handshake;
    logic             tail_valid;
    logic             tail_ghost;
    logic             tail_id;
    logic             push;
    logic             pop;
    logic             err_set;
    logic             fifo_nonempty;
    logic [ENT_W-1:0] head_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Round-robin arbitration; ready is suppressed while reset is held,
    // during a flush cycle, or when no credit is left.
    always_comb begin
        gnt_id    = 1'b0;
        issue_ok  = ~reset & (credits_reg != '0) & ~flush;
        case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = rr_ptr_reg;
            default: gnt_id = 1'b0;
        endcase
        gnt_any   = (|req_valid) & issue_ok;
        handshake = gnt_any;
        req_ready = 2'b00;
        if (gnt_any) begin
            req_ready = gnt_id ? 2'b10 : 2'b01;
        end
    end

    // Rotate priority away from whichever port just won.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_reg <= 1'b0;
        end else if (handshake) begin
            rr_ptr_reg <= ~gnt_id;
        end
    end

    // Issue register: operand fields hold their last value between issues.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cvt_valid_reg <= 1'b0;
            cvt_id_reg    <= 1'b0;
            cvt_op_reg    <= '0;
            cvt_data_reg  <= '0;
            cvt_class_reg <= '0;
            cvt_rm_reg    <= '0;
        end else begin
            cvt_valid_reg <= handshake;
            if (handshake) begin
                cvt_id_reg    <= gnt_id;
                cvt_op_reg    <= port_op[gnt_id];
                cvt_data_reg  <= port_data[gnt_id];
                cvt_class_reg <= port_class[gnt_id];
                cvt_rm_reg    <= port_rm[gnt_id];
            end
        end
    end

    assign cvt_valid = cvt_valid_reg;
    assign cvt_op    = cvt_op_reg;
    assign cvt_data  = cvt_data_reg;
    assign cvt_class = cvt_class_reg;
    assign cvt_rm    = cvt_rm_reg;

    // ------------------------------------------------------------------
    // In-flight tracking. Each stage carries a live valid plus a "ghost"
    // bit for ops killed by flush: the datapath still returns those, and
    // the ghost lets us swallow that result without flagging an error.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LAT; gi++) begin : g_track
        if (gi == 0) begin : g_first
            assign stage_in_valid[gi] = cvt_valid_reg;
            assign stage_in_ghost[gi] = 1'b0;
            assign stage_in_id[gi]    = cvt_id_reg;
        end else begin : g_next
            assign stage_in_valid[gi] = stage_valid_reg[gi-1];
            assign stage_in_ghost[gi] = stage_ghost_reg[gi-1];
            assign stage_in_id[gi]    = stage_id_reg[gi-1];
        end
    end

    // Shift the tracker every cycle; a flush turns every live op into a ghost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_valid_reg <= '0;
            stage_ghost_reg <= '0;
            stage_id_reg    <= '0;
        end else if (flush) begin
            stage_valid_reg <= '0;
            stage_ghost_reg <= stage_in_valid | stage_in_ghost;
            stage_id_reg    <= stage_in_id;
        end else begin
            stage_valid_reg <= stage_in_valid;
            stage_ghost_reg <= stage_in_ghost;
            stage_id_reg    <= stage_in_id;
        end
    end

    assign tail_valid = stage_valid_reg[LAT-1];
    assign tail_ghost = stage_ghost_reg[LAT-1];
    assign tail_id    = stage_id_reg[LAT-1];

    // Result capture and protocol check. Nothing is captured or checked
    // in the flush cycle, and results of killed ops are ignored.
    assign push    = tail_valid & res_valid & ~flush;
    assign err_set = ~flush & ~tail_ghost & (res_valid != tail_valid);

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    assign fifo_nonempty = (count_reg != '0);
    assign pop           = fifo_nonempty & rsp_ready & ~flush;
    assign head_entry    = fifo_mem[rd_ptr_reg];

    // Storage array, written on push only.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {tail_id, res_result, res_flags};
        end
    end

    // Pointers and occupancy; credits keep push from ever meeting a full FIFO.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head outputs read as zero when empty so reset leaves a clean bus.
    assign rsp_valid  = fifo_nonempty;
    assign rsp_id     = fifo_nonempty ? head_entry[ENT_W-1] : 1'b0;
    assign rsp_result = fifo_nonempty ? head_entry[36:5] : 32'd0;
    assign rsp_flags  = fifo_nonempty ? head_entry[4:0] : 5'd0;

    // Credits: one per FIFO slot, taken on issue and returned on pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            credits_reg <= CNT_W'(DEPTH);
        end else if (flush) begin
            credits_reg <= CNT_W'(DEPTH);
        end else if (handshake && !pop) begin
            credits_reg <= credits_reg - CNT_W'(1);
        end else if (pop && !handshake) begin
            credits_reg <= credits_reg + CNT_W'(1);
        end
    end

    // Sticky exception flags; clear wins over a same-cycle accumulate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fflags_reg <= '0;
        end else if (fflags_clr) begin
            fflags_reg <= '0;
        end else if (pop) begin
            fflags_reg <= fflags_reg | head_entry[4:0];
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (err_set) begin
            err_reg <= 1'b1;
        end
    end

    assign fflags = fflags_reg;
    assign err    = err_reg;

endmodule

// File: tb/tb_fp_cvt_sched.sv
// tb_fp_cvt_sched: directed, table-driven bench for fp_cvt_sched with a
// fixed-latency datapath stand-in and an in-order response scoreboard.
module tb_fp_cvt_sched;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_op;
    logic [65:0] req_data;
    logic [19:0] req_class;
    logic [5:0]  req_rm;
    logic        cvt_valid;
    logic [1:0]  cvt_op;
    logic [32:0] cvt_data;
    logic [9:0]  cvt_class;
    logic [2:0]  cvt_rm;
    logic        res_valid;
    logic [31:0] res_result;
    logic [4:0]  res_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_flags;
    logic        flush;
    logic [4:0]  fflags;
    logic        fflags_clr;
    logic        err;
    logic        inj_valid;

    always #5 clock = ~clock;

    fp_cvt_sched #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_class(req_class), .req_rm(req_rm),
        .cvt_valid(cvt_valid), .cvt_op(cvt_op), .cvt_data(cvt_data),
        .cvt_class(cvt_class), .cvt_rm(cvt_rm),
        .res_valid(res_valid), .res_result(res_result), .res_flags(res_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .flush(flush), .fflags(fflags), .fflags_clr(fflags_clr), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Datapath stand-in: recoded 1.5 converts to 2 inexact; anything else
    // gets a simple reversible mapping so ordering errors are visible.
    function automatic logic [36:0] dp_model(input logic [32:0] d);
        if (d == 33'h0_8040_0000) return {32'd2, 5'b00001};
        return {d[31:0] ^ 32'hFFFF_0000, d[4:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_port(input int p, input logic [1:0] op, input logic [32:0] d,
                            input logic [9:0] c, input logic [2:0] rm);
        req_op[p*2 +: 2]     = op;
        req_data[p*33 +: 33] = d;
        req_class[p*10 +: 10] = c;
        req_rm[p*3 +: 3]     = rm;
    endtask

    // Fixed-latency datapath: returns each issued op exactly LAT cycles later.
    logic [LAT-1:0] dp_v;
    logic [32:0]    dp_d [LAT];
    logic [36:0]    dp_out;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dp_v <= '0;
        end else begin
            dp_v[0] <= cvt_valid;
            dp_d[0] <= cvt_data;
            for (int k = 1; k < LAT; k++) begin
                dp_v[k] <= dp_v[k-1];
                dp_d[k] <= dp_d[k-1];
            end
        end
    end
    assign dp_out     = dp_model(dp_d[LAT-1]);
    assign res_valid  = dp_v[LAT-1] | inj_valid;
    assign res_result = dp_out[36:5];
    assign res_flags  = dp_out[4:0];

    // Scoreboard: every handshake queues its expected response; every pop
    // must match the queue head.
    typedef struct packed {
        logic        id;
        logic [31:0] result;
        logic [4:0]  flags;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t sb_e;
    int   hs_count  = 0;
    int   pop_count = 0;

    always @(negedge clock) begin
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                pop_count++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got id=%0d result=%0h, required no response",
                             rsp_id, rsp_result);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_rsp", {26'd0, rsp_id, rsp_result, rsp_flags},
                          {26'd0, sb_e.id, sb_e.result, sb_e.flags});
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_e.id = i[0];
                    {sb_e.result, sb_e.flags} = dp_model(req_data[i*33 +: 33]);
                    exp_q.push_back(sb_e);
                    hs_count++;
                    $display("grant port %0d data=%0h", i, req_data[i*33 +: 33]);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 40) begin
            step();
            n++;
        end
        check({name, "_queue"}, exp_q.size(), 0);
        check({name, "_rsp_valid"}, rsp_valid, 0);
    endtask

    typedef struct {
        int          port;
        logic [1:0]  op;
        logic [32:0] data;
        logic [9:0]  cls;
        logic [2:0]  rm;
        logic [31:0] exp_result;
        logic [4:0]  exp_flags;
    } single_t;

    typedef struct {
        logic [1:0] valid;
        logic [1:0] exp_ready;
    } cont_t;

    single_t sv [4];
    cont_t   ct [7];
    logic [4:0] exp_ff;
    int hs0;
    int pop0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sv[0] = '{0, 2'd0, 33'h0_8040_0000, 10'h040, 3'd0, 32'h0000_0002, 5'b00001};
        sv[1] = '{1, 2'd2, 33'h0_0000_0007, 10'h000, 3'd1, 32'hFFFF_0007, 5'b00111};
        sv[2] = '{0, 2'd1, 33'h1_2345_6789, 10'h002, 3'd2, 32'hDCBA_6789, 5'b01001};
        sv[3] = '{1, 2'd3, 33'h0_0000_0010, 10'h000, 3'd4, 32'hFFFF_0010, 5'b10000};

        ct[0] = '{2'b11, 2'b01};
        ct[1] = '{2'b11, 2'b10};
        ct[2] = '{2'b11, 2'b01};
        ct[3] = '{2'b11, 2'b10};
        ct[4] = '{2'b11, 2'b00};  // all four credits out, none popped yet
        ct[5] = '{2'b11, 2'b01};
        ct[6] = '{2'b11, 2'b10};

        req_valid = 0; req_op = 0; req_data = 0; req_class = 0; req_rm = 0;
        rsp_ready = 0; flush = 0; fflags_clr = 0; inj_valid = 0;

        // ---------------- reset state ----------------
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 req_valid = 2'b11;
        #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_cvt_valid", cvt_valid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_fflags", fflags, 0);
        check("rst_err", err, 0);
        req_valid = 2'b00;
        reset = 1'b0;

        // ---------------- single requests ----------------
        exp_ff = 5'd0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_port(sv[i].port, sv[i].op, sv[i].data, sv[i].cls, sv[i].rm);
            req_valid = (sv[i].port == 0) ? 2'b01 : 2'b10;
            #1 check("single_ready", req_ready, (sv[i].port == 0) ? 2'b01 : 2'b10);
            step();
            req_valid = 2'b00;
            #1;
            check("single_cvt_valid", cvt_valid, 1);
            check("single_cvt_fields", {cvt_op, cvt_data, cvt_class, cvt_rm},
                  {sv[i].op, sv[i].data, sv[i].cls, sv[i].rm});
            for (int k = 1; k <= LAT + 2; k++) begin
                if (k > 1) step();
                #1 check("single_latency_rsp_valid", rsp_valid, (k == LAT + 2));
            end
            check("single_rsp_id", rsp_id, sv[i].port[0]);
            check("single_rsp_result", rsp_result, sv[i].exp_result);
            check("single_rsp_flags", rsp_flags, sv[i].exp_flags);
            step();
            exp_ff = exp_ff | sv[i].exp_flags;
            #1 check("single_fflags", fflags, exp_ff);
        end
        check("single_err", err, 0);
        fflags_clr = 1'b1;
        step();
        fflags_clr = 1'b0;
        #1 check("fflags_clr", fflags, 0);

        // ---------------- contention ----------------
        hs0 = hs_count;
        for (int i = 0; i < 7; i++) begin
            req_valid = ct[i].valid;
            set_port(0, 2'd0, 33'h0_0000_1000 | 33'(i), 10'h040, 3'd0);
            set_port(1, 2'd2, 33'h0_0000_2000 | 33'(i), 10'h000, 3'd1);
            #1 check("cont_ready", req_ready, ct[i].exp_ready);
            step();
        end
        req_valid = 2'b00;
        check("cont_grants", hs_count - hs0, 6);
        wait_drain("cont_drain");

        // ---------------- backpressure ----------------
        rsp_ready = 1'b0;
        hs0  = hs_count;
        pop0 = pop_count;
        req_valid = 2'b01;
        for (int j = 0; j < 10; j++) begin
            set_port(0, 2'd1, 33'h0_0000_0300 + 33'(j), 10'h002, 3'd3);
            step();
        end
        #1;
        check("bp_handshakes", hs_count - hs0, DEPTH);
        check("bp_ready_low", req_ready, 2'b00);
        check("bp_rsp_valid", rsp_valid, 1);
        if (exp_q.size() != 0) check("bp_head_stable", rsp_result, exp_q[0].result);
        set_port(0, 2'd1, 33'h0_0000_0400, 10'h002, 3'd3);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        hs0 = hs_count;
        repeat (8) step();
        check("bp_one_more_grant", hs_count - hs0, 1);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_pops", pop_count - pop0, DEPTH + 1);

        // ---------------- flush ----------------
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        for (int j = 0; j < 3; j++) begin
            set_port(0, 2'd0, 33'h0_0000_0500 + 33'(j), 10'h040, 3'd0);
            step();
        end
        req_valid = 2'b00;
        step();
        flush = 1'b1;
        req_valid = 2'b01;
        #1;
        check("flush_no_grant", req_ready, 2'b00);
        check("flush_buffered", rsp_valid, 1);
        step();
        flush = 1'b0;
        req_valid = 2'b00;
        #1;
        check("flush_rsp_valid", rsp_valid, 0);
        check("flush_cvt_valid", cvt_valid, 0);
        repeat (4) step();
        check("flush_err", err, 0);
        check("flush_still_empty", rsp_valid, 0);
        hs0 = hs_count;
        req_valid = 2'b01;
        for (int j = 0; j < 8; j++) begin
            set_port(0, 2'd0, 33'h0_0000_0600 + 33'(j), 10'h040, 3'd0);
            step();
        end
        req_valid = 2'b00;
        check("flush_credits", hs_count - hs0, DEPTH);
        rsp_ready = 1'b1;
        wait_drain("flush_drain");

        // ---------------- protocol error ----------------
        rsp_ready = 1'b0;
        pop0 = pop_count;
        set_port(1, 2'd2, 33'h0_0000_0777, 10'h000, 3'd0);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        repeat (LAT + 3) step();
        inj_valid = 1'b1;
        step();
        inj_valid = 1'b0;
        #1;
        check("perr_err_set", err, 1);
        check("perr_fifo_head_valid", rsp_valid, 1);
        if (exp_q.size() != 0) check("perr_fifo_head", rsp_result, exp_q[0].result);
        repeat (3) step();
        check("perr_err_sticky", err, 1);
        rsp_ready = 1'b1;
        wait_drain("perr_drain");
        check("perr_pops", pop_count - pop0, 1);

        // ---------------- async reset mid-stream ----------------
        rsp_ready = 1'b0;
        req_valid = 2'b01;
        for (int j = 0; j < 3; j++) begin
            set_port(0, 2'd1, 33'h0_0000_0800 + 33'(j), 10'h002, 3'd5);
            step();
        end
        #1 check("arst_credit_left", req_ready, 2'b01);
        #2 reset = 1'b1;
        #1;
        check("arst_req_ready", req_ready, 2'b00);
        check("arst_cvt_valid", cvt_valid, 0);
        check("arst_cvt_fields", {cvt_op, cvt_data, cvt_class, cvt_rm}, 0);
        check("arst_rsp", {rsp_valid, rsp_id, rsp_result, rsp_flags}, 0);
        check("arst_fflags", fflags, 0);
        check("arst_err", err, 0);
        req_valid = 2'b00;
        repeat (2) step();
        reset = 1'b0;
        set_port(1, 2'd3, 33'h0_0000_0099, 10'h000, 3'd2);
        req_valid = 2'b10;
        #1 check("arst_port1_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        #1;
        check("arst_cvt_issue", {cvt_valid, cvt_op, cvt_data}, {1'b1, 2'd3, 33'h0_0000_0099});
        rsp_ready = 1'b1;
        pop0 = pop_count;
        wait_drain("arst_drain");
        check("arst_pops", pop_count - pop0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
